// File: rtl/l2cache_ctrl_nway_pkg.sv
// Shared types for the L2 cache control FSM.
// State and requester-source encodings.
package l2cache_ctrl_nway_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_OP     = 3'd2,
    ST_WBACK  = 3'd3,
    ST_FILL   = 3'd4,
    ST_STORE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SRC_I  = 2'd0,
    SRC_D  = 2'd1,
    SRC_OP = 2'd2
  } src_t;

endpackage

// File: rtl/l2cache_ctrl_nway_arb.sv
// Request arbiter for the L2 controller.
// Cache ops win outright; I and D alternate when both pend.
module l2cache_ctrl_nway_arb
  import l2cache_ctrl_nway_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic op_req_i,
  output logic gnt_o,
  output src_t src_o
);

  // 1 = D was the last I/D grant, so I wins the next tie
  logic rr_d_q;

  // Grant decode: op first, then round-robin I vs D
  always_comb begin
    gnt_o = 1'b0;
    src_o = SRC_I;
    if (op_req_i) begin
      gnt_o = 1'b1;
      src_o = SRC_OP;
    end else if (i_req_i && d_req_i) begin
      gnt_o = 1'b1;
      src_o = rr_d_q ? SRC_I : SRC_D;
    end else if (i_req_i) begin
      gnt_o = 1'b1;
      src_o = SRC_I;
    end else if (d_req_i) begin
      gnt_o = 1'b1;
      src_o = SRC_D;
    end
  end

  // Remember the last I/D winner; op grants leave it alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_d_q <= 1'b1;
    end else if (en_i && gnt_o && (src_o != SRC_OP)) begin
      rr_d_q <= (src_o == SRC_D);
    end
  end

endmodule

// File: rtl/l2cache_ctrl_nway.sv
// Control FSM for the shared N-way L2 cache.
// Drives datapath selects and write enables only.
module l2cache_ctrl_nway
  import l2cache_ctrl_nway_pkg::*;
#(
  parameter  int WAYS       = 2,
  parameter  int LINE_WORDS = 4,
  localparam int WB         = $clog2(WAYS),
  localparam int LB         = $clog2(LINE_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          op_req,
  input  logic          op_store,
  input  logic [WAYS-1:0] hit_vec,
  input  logic [WAYS-1:0] v_vec,
  input  logic [WAYS-1:0] d_vec,
  input  logic [WB-1:0] lru_way,
  input  logic          mem_ready,
  output logic          i_ready,
  output logic          d_ready,
  output logic          op_ready,
  output logic          addr_s,
  output logic [WB-1:0] way_sel,
  output logic [LB-1:0] word_idx,
  output logic          t_w,
  output logic          v_w,
  output logic          v_wdata,
  output logic          d_w,
  output logic          d_wdata,
  output logic          da_w,
  output logic          da_ds,
  output logic          data_mem,
  output logic          mem_r,
  output logic          mem_w,
  output logic          mem_write_back,
  output logic          cache_tag_w,
  output logic          lru_upd,
  output logic          busy
);

  state_t        state_q, state_d;
  logic [LB-1:0] cnt_q, cnt_d;
  logic [WB-1:0] vic_q, vic_d;
  src_t          src_q, src_d;
  logic          we_q, we_d;
  logic          st_q, st_d;
  logic          as_q, as_d;

  logic          gnt;
  src_t          gsrc;
  logic          rdy;
  logic          hit;
  logic [WB-1:0] hit_way;
  logic          any_inv;
  logic [WB-1:0] inv_way;
  logic [WB-1:0] vic_way;
  logic          vic_wb;
  logic          last;

  l2cache_ctrl_nway_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .en_i     (state_q == ST_IDLE),
    .i_req_i  (i_req),
    .d_req_i  (d_req),
    .op_req_i (op_req),
    .gnt_o    (gnt),
    .src_o    (gsrc)
  );

  // Hit way and victim choice; lowest index wins on ties
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WB'(w);
      if (!v_vec[w])  inv_way = WB'(w);
    end
    hit     = |hit_vec;
    any_inv = ~&v_vec;
    vic_way = any_inv ? inv_way : lru_way;
    vic_wb  = !any_inv && d_vec[lru_way];
    last    = (cnt_q == LB'(LINE_WORDS - 1));
  end

  // Next state, per-transaction latches and datapath controls
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    vic_d          = vic_q;
    src_d          = src_q;
    we_d           = we_q;
    st_d           = st_q;
    as_d           = as_q;
    rdy            = 1'b0;
    way_sel        = '0;
    word_idx       = '0;
    t_w            = 1'b0;
    v_w            = 1'b0;
    v_wdata        = 1'b0;
    d_w            = 1'b0;
    d_wdata        = 1'b0;
    da_w           = 1'b0;
    da_ds          = 1'b0;
    data_mem       = 1'b0;
    mem_r          = 1'b0;
    mem_w          = 1'b0;
    mem_write_back = 1'b0;
    cache_tag_w    = 1'b0;
    lru_upd        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt) begin
          src_d   = gsrc;
          we_d    = d_we && (gsrc == SRC_D);
          st_d    = op_store;
          as_d    = (gsrc == SRC_I);
          cnt_d   = '0;
          state_d = (gsrc == SRC_OP) ? ST_OP : ST_LOOKUP;
        end
      end
      ST_OP: begin
        rdy         = 1'b1;
        t_w         = st_q;
        cache_tag_w = !st_q;
        state_d     = ST_IDLE;
      end
      ST_LOOKUP: begin
        if (hit) begin
          way_sel = hit_way;
          rdy     = 1'b1;
          lru_upd = 1'b1;
          if (we_q) begin
            da_w    = 1'b1;
            da_ds   = 1'b1;
            d_w     = 1'b1;
            d_wdata = 1'b1;
          end
          state_d = ST_IDLE;
        end else begin
          way_sel = vic_way;
          vic_d   = vic_way;
          cnt_d   = '0;
          state_d = vic_wb ? ST_WBACK : ST_FILL;
        end
      end
      ST_WBACK: begin
        way_sel        = vic_q;
        word_idx       = cnt_q;
        mem_w          = 1'b1;
        mem_write_back = 1'b1;
        if (mem_ready) begin
          cnt_d = cnt_q + LB'(1);
          if (last) begin
            cnt_d   = '0;
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        way_sel  = vic_q;
        word_idx = cnt_q;
        mem_r    = 1'b1;
        if (mem_ready) begin
          da_w  = 1'b1;
          cnt_d = cnt_q + LB'(1);
          if (last) begin
            cnt_d   = '0;
            state_d = ST_STORE;
          end
        end
      end
      ST_STORE: begin
        way_sel = vic_q;
        t_w     = 1'b1;
        v_w     = 1'b1;
        v_wdata = 1'b1;
        d_w     = 1'b1;
        d_wdata = we_q;
        // requester word lands at the address offset the datapath holds
        da_w    = we_q;
        da_ds   = we_q;
        data_mem = !we_q;
        rdy     = 1'b1;
        lru_upd = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign i_ready  = rdy && (src_q == SRC_I);
  assign d_ready  = rdy && (src_q == SRC_D);
  assign op_ready = rdy && (src_q == SRC_OP);
  assign addr_s   = as_q;
  assign busy     = (state_q != ST_IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Beat counter, victim way and granted-request latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      vic_q <= '0;
      src_q <= SRC_I;
      we_q  <= 1'b0;
      st_q  <= 1'b0;
      as_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      vic_q <= vic_d;
      src_q <= src_d;
      we_q  <= we_d;
      st_q  <= st_d;
      as_q  <= as_d;
    end
  end

endmodule

// File: tb/tb_l2cache_ctrl_nway.sv
// Scoreboard bench for l2cache_ctrl_nway (WAYS=2, LINE_WORDS=4).
// Stimulus pushes expected completions; a monitor pops on each ready.
module tb_l2cache_ctrl_nway;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_req = 0, d_req = 0, d_we = 0, op_req = 0, op_store = 0;
  logic [1:0] hit_vec = 0, v_vec = 0, d_vec = 0;
  logic lru_way = 0;
  logic mem_ready = 1'b1;
  logic i_ready, d_ready, op_ready, addr_s;
  logic way_sel;
  logic [1:0] word_idx;
  logic t_w, v_w, v_wdata, d_w, d_wdata, da_w, da_ds, data_mem;
  logic mem_r, mem_w, mem_write_back, cache_tag_w, lru_upd, busy;
  logic [20:0] outs;
  bit gap = 0;

  always #5 clk = ~clk;

  l2cache_ctrl_nway #(.WAYS(2), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .d_req(d_req), .d_we(d_we),
    .op_req(op_req), .op_store(op_store),
    .hit_vec(hit_vec), .v_vec(v_vec), .d_vec(d_vec),
    .lru_way(lru_way), .mem_ready(mem_ready),
    .i_ready(i_ready), .d_ready(d_ready), .op_ready(op_ready),
    .addr_s(addr_s), .way_sel(way_sel), .word_idx(word_idx),
    .t_w(t_w), .v_w(v_w), .v_wdata(v_wdata),
    .d_w(d_w), .d_wdata(d_wdata),
    .da_w(da_w), .da_ds(da_ds), .data_mem(data_mem),
    .mem_r(mem_r), .mem_w(mem_w),
    .mem_write_back(mem_write_back),
    .cache_tag_w(cache_tag_w), .lru_upd(lru_upd), .busy(busy)
  );

  assign outs = {i_ready, d_ready, op_ready, addr_s, way_sel,
                 word_idx, t_w, v_w, v_wdata, d_w, d_wdata,
                 da_w, da_ds, data_mem, mem_r, mem_w,
                 mem_write_back, cache_tag_w, lru_upd, busy};

  // flags: {addr_s,lru,data_mem,da_ds,d_w,d_wdata,t_w,v_w&v_wdata,tag_cap}
  typedef struct packed {
    logic [1:0] src;
    logic       way;
    logic [2:0] wb_n;
    logic [2:0] fill_n;
    logic [2:0] daw_n;
    logic [7:0] wb_seq;
    logic [7:0] fill_seq;
    logic [8:0] flags;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(logic [1:0] s, logic w, logic [2:0] wb,
                              logic [2:0] fl, logic [2:0] da,
                              logic [8:0] f);
    exp_t e;
    e.src      = s;
    e.way      = w;
    e.wb_n     = wb;
    e.fill_n   = fl;
    e.daw_n    = da;
    e.wb_seq   = (wb == 3'd4) ? 8'he4 : 8'h00;
    e.fill_seq = (fl == 3'd4) ? 8'he4 : 8'h00;
    e.flags    = f;
    return e;
  endfunction

  // memory beat pacing: always ready, or 1 cycle in 3
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (gap) begin
        mem_ready = (ph == 0);
        ph = (ph == 2) ? 0 : ph + 1;
      end else begin
        mem_ready = 1'b1;
      end
    end
  end

  // monitor: accumulate beats, compare on every ready pulse
  initial begin
    int wbn = 0, fln = 0, dan = 0;
    logic [7:0] wbs = 0, fls = 0;
    exp_t e;
    logic [1:0] sa;
    forever begin
      @(negedge clk);
      if (rst) begin
        wbn = 0; fln = 0; dan = 0; wbs = 0; fls = 0;
      end else begin
        if (mem_w && mem_ready) begin
          wbn++;
          wbs = {word_idx, wbs[7:2]};
        end
        if (mem_r && mem_ready) begin
          fln++;
          fls = {word_idx, fls[7:2]};
        end
        if (da_w) dan++;
        if (i_ready || d_ready || op_ready) begin
          chk("ready_onehot", $countones({i_ready, d_ready, op_ready}), 1);
          if (q.size() == 0) begin
            chk("unexpected_ready", 1, 0);
          end else begin
            e = q.pop_front();
            sa = op_ready ? 2'd2 : (d_ready ? 2'd1 : 2'd0);
            chk("src", sa, e.src);
            chk("way_sel", way_sel, e.way);
            chk("wb_beats", wbn, e.wb_n);
            chk("fill_beats", fln, e.fill_n);
            chk("da_w_pulses", dan, e.daw_n);
            chk("wb_word_idx", wbs, e.wb_seq);
            chk("fill_word_idx", fls, e.fill_seq);
            chk("flags", {addr_s, lru_upd, data_mem, da_ds, d_w, d_wdata,
                          t_w, v_w & v_wdata, cache_tag_w}, e.flags);
          end
          wbn = 0; fln = 0; dan = 0; wbs = 0; fls = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int lat);
    bit got = 0;
    lat = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      lat++;
      if (i_ready || d_ready || op_ready) begin
        got = 1;
        break;
      end
    end
    chk("ready_seen", got, 1);
    tick();
  endtask

  task automatic run(bit ii, bit dd, bit we, logic [1:0] hv,
                     logic [1:0] vv, logic [1:0] dv, logic lw,
                     exp_t e, output int lat);
    q.push_back(e);
    hit_vec = hv; v_vec = vv; d_vec = dv; lru_way = lw;
    d_we = we; i_req = ii; d_req = dd;
    wait_ready(lat);
    i_req = 0; d_req = 0; d_we = 0;
  endtask

  initial begin
    int lat;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", outs, 0);
    rst = 0;
    tick();
    chk("idle_outs", outs, 0);

    // I read hit on way 1, two-cycle latency
    run(1, 0, 0, 2'b10, 2'b11, 2'b00, 0, mk(0, 1, 0, 0, 0, 9'h180), lat);
    chk("hit_latency", lat, 2);
    // multi-hot: lowest way wins
    run(1, 0, 0, 2'b11, 2'b11, 2'b00, 1, mk(0, 0, 0, 0, 0, 9'h180), lat);
    // D read miss, dirty LRU victim way 0: write-back then fill
    run(0, 1, 0, 2'b00, 2'b11, 2'b01, 0, mk(1, 0, 4, 4, 4, 9'h0D6), lat);
    // D read miss, dirty LRU victim way 1
    run(0, 1, 0, 2'b00, 2'b11, 2'b10, 1, mk(1, 1, 4, 4, 4, 9'h0D6), lat);
    // D write miss into invalid way 1: fill then merge
    run(0, 1, 1, 2'b00, 2'b01, 2'b01, 0, mk(1, 1, 0, 4, 5, 9'h0BE), lat);
    // D write hit way 0
    run(0, 1, 1, 2'b01, 2'b11, 2'b00, 1, mk(1, 0, 0, 0, 1, 9'h0B8), lat);
    // index-load-tag and index-store-tag ops
    q.push_back(mk(2, 0, 0, 0, 0, 9'h001));
    op_store = 0; op_req = 1;
    wait_ready(lat);
    op_req = 0;
    q.push_back(mk(2, 0, 0, 0, 0, 9'h004));
    op_store = 1; op_req = 1;
    wait_ready(lat);
    op_req = 0; op_store = 0;

    // round-robin from reset, op cuts in
    rst = 1;
    tick();
    chk("reset2_outs", outs, 0);
    rst = 0;
    tick();
    q.push_back(mk(0, 0, 0, 0, 0, 9'h180));
    q.push_back(mk(1, 0, 0, 0, 0, 9'h080));
    q.push_back(mk(0, 0, 0, 0, 0, 9'h180));
    q.push_back(mk(1, 0, 0, 0, 0, 9'h080));
    q.push_back(mk(2, 0, 0, 0, 0, 9'h001));
    q.push_back(mk(0, 0, 0, 0, 0, 9'h180));
    hit_vec = 2'b01; v_vec = 2'b11; d_vec = 2'b00;
    i_req = 1; d_req = 1;
    repeat (4) wait_ready(lat);
    op_store = 0; op_req = 1;
    wait_ready(lat);
    op_req = 0;
    wait_ready(lat);
    i_req = 0; d_req = 0;
    tick();

    // gapped memory: exactly four fill writes
    gap = 1;
    run(0, 1, 0, 2'b00, 2'b11, 2'b00, 1, mk(1, 1, 0, 4, 4, 9'h0D6), lat);

    // reset in the middle of a fill
    hit_vec = 2'b00; v_vec = 2'b11; d_vec = 2'b00; lru_way = 0;
    d_req = 1;
    repeat (6) tick();
    chk("mid_fill_mem_r", mem_r, 1);
    rst = 1;
    #1;
    chk("rst_mid_fill_outs", outs, 0);
    d_req = 0;
    repeat (2) tick();
    rst = 0;
    gap = 0;
    tick();
    chk("post_rst_busy", busy, 0);

    // recovery after abandoned burst
    run(1, 0, 0, 2'b10, 2'b11, 2'b00, 0, mk(0, 1, 0, 0, 0, 9'h180), lat);
    repeat (2) tick();
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
